serial_subtractor: RTL and testbench

Multi-cycle, bit-serial unsigned/two's-complement subtractor. It is the inverse-operation companion to the team's ripple-carry adder. Operands are captured on a start pulse and processed LSB-first through a single full-subtractor cell with a registered borrow. After WIDTH cycles the block presents the difference, borrow-out and signed overflow. It serves area-constrained datapaths where one result every WIDTH+1 cycles is sufficient.

---
 rtl/serial_subtractor.sv | 136 +++++++++++++
 tb/tb_serial_subtractor.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : bit-serial a - b - bo subtractor, one full-subtractor
// cell with a registered borrow, LSB first.            Revision: 1.0
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bo_in,
  output logic             ready_out,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] d_out,
  output logic             bo_out,
  output logic             ov_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic             br_q,     br_d;
  logic             a_msb_q,  a_msb_d;
  logic             b_msb_q,  b_msb_d;
  logic [WIDTH-1:0] d_q,      d_d;
  logic             bo_q,     bo_d;
  logic             ov_q,     ov_d;
  logic             done_q,   done_d;

  logic             diff_w;
  logic             br_next_w;

  // Full-subtractor cell on the current LSB of the working operands.
  assign diff_w    = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next_w = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    d_d     = d_q;
    bo_d    = bo_q;
    ov_d    = ov_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          a_d     = a_in;
          b_d     = b_in;
          br_d    = bo_in;
          a_msb_d = a_in[WIDTH-1];
          b_msb_d = b_in[WIDTH-1];
          res_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {diff_w, res_q[WIDTH-1:1]};
        br_d  = br_next_w;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          d_d     = res_d;
          bo_d    = br_next_w;
          ov_d    = (a_msb_q ^ b_msb_q) & (res_d[WIDTH-1] ^ a_msb_q);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
    end
  end

  assign ready_out = (state_q == IDLE);
  assign busy_out  = (state_q == SHIFT);
  assign done_out  = done_q;
  assign d_out     = d_q;
  assign bo_out    = bo_q;
  assign ov_out    = ov_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// tb_serial_subtractor : directed self-checking bench for serial_subtractor.
//                                                      Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk_in;
  logic             rst_in;
  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             bo_in;
  logic             ready_out;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] d_out;
  logic             bo_out;
  logic             ov_out;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start_in  (start_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .bo_in     (bo_in),
    .ready_out (ready_out),
    .busy_out  (busy_out),
    .done_out  (done_out),
    .d_out     (d_out),
    .bo_out    (bo_out),
    .ov_out    (ov_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full operation; prev_d is the result that must hold during SHIFT.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bo,
                        input logic [3:0] ed, input logic ebo, input logic eov,
                        input logic [3:0] prev_d);
    @(negedge clk_in);
    a_in = a; b_in = b; bo_in = bo; start_in = 1'b1;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    a_in = ~a; b_in = ~b; bo_in = ~bo;
    check("busy_after_start", {31'd0, busy_out}, 32'd1);
    check("ready_after_start", {31'd0, ready_out}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in);
      #1;
      check("busy_shift", {31'd0, busy_out}, 32'd1);
      check("done_early", {31'd0, done_out}, 32'd0);
      check("d_hold", {28'd0, d_out}, {28'd0, prev_d});
    end
    @(posedge clk_in);
    #1;
    check("done_pulse", {31'd0, done_out}, 32'd1);
    check("ready_done", {31'd0, ready_out}, 32'd1);
    check("d_out", {28'd0, d_out}, {28'd0, ed});
    check("bo_out", {31'd0, bo_out}, {31'd0, ebo});
    check("ov_out", {31'd0, ov_out}, {31'd0, eov});
    @(posedge clk_in);
    #1;
    check("done_one_cycle", {31'd0, done_out}, 32'd0);
  endtask

  initial begin
    logic [3:0] s_d [3];
    logic       s_bo[3];
    rst_in = 1'b1; start_in = 1'b0; a_in = '0; b_in = '0; bo_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("rst_d", {28'd0, d_out}, 32'd0);
    check("rst_bo", {31'd0, bo_out}, 32'd0);
    check("rst_ov", {31'd0, ov_out}, 32'd0);
    check("rst_done", {31'd0, done_out}, 32'd0);
    check("rst_ready", {31'd0, ready_out}, 32'd1);
    check("rst_busy", {31'd0, busy_out}, 32'd0);

    // Signed overflow follows (a.msb != b.msb) && (d.msb != a.msb).
    run_op(4'd9, 4'd3, 1'b0, 4'd6,  1'b0, 1'b1, 4'd0);
    run_op(4'd3, 4'd9, 1'b0, 4'd10, 1'b1, 1'b1, 4'd6);
    run_op(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0, 4'd10);
    run_op(4'd8, 4'd1, 1'b0, 4'd7,  1'b0, 1'b1, 4'd15);
    run_op(4'd7, 4'd15, 1'b0, 4'd8, 1'b1, 1'b1, 4'd7);

    // Start held high, operands a=k+1, b=3k at edge k; accepted at k=0,5,10.
    s_d[0] = 4'd1;  s_bo[0] = 1'b0;
    s_d[1] = 4'd7;  s_bo[1] = 1'b1;
    s_d[2] = 4'd13; s_bo[2] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk_in);
      a_in = 4'(k + 1); b_in = 4'(3 * k); bo_in = 1'b0;
      start_in = 1'b1;
      @(posedge clk_in);
      #1;
      check("stream_done", {31'd0, done_out}, {31'd0, (k % 5 == 4)});
      if (k % 5 == 4) begin
        check("stream_d", {28'd0, d_out}, {28'd0, s_d[k / 5]});
        check("stream_bo", {31'd0, bo_out}, {31'd0, s_bo[k / 5]});
        check("stream_ov", {31'd0, ov_out}, 32'd0);
      end
    end
    @(negedge clk_in);
    start_in = 1'b0;
    @(posedge clk_in);
    #1;
    check("stream_idle", {31'd0, ready_out}, 32'd1);

    // Abort on the second SHIFT cycle.
    @(negedge clk_in);
    a_in = 4'd12; b_in = 4'd5; bo_in = 1'b0; start_in = 1'b1;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    check("abort_d", {28'd0, d_out}, 32'd0);
    check("abort_bo", {31'd0, bo_out}, 32'd0);
    check("abort_ready", {31'd0, ready_out}, 32'd1);
    check("abort_busy", {31'd0, busy_out}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_in);
      #1;
      check("abort_no_done", {31'd0, done_out}, 32'd0);
    end
    run_op(4'd12, 4'd5, 1'b0, 4'd7, 1'b0, 1'b1, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
